wb_stage_pipe: RTL

//  Registered MEM/WB pipeline stage plus write-back for the MIPS core.
//  - Captures MEM-stage results and selects the write-back source: ALU, memory, PC+4 link or LUI immediate.
//  - Extracts sub-word load data and drives the register-file write port.
//  - Exposes a forwarding tap and a retired-instruction counter.
//  - Sits between the MEM stage and the register file; parametrised in data and register-address width.

---
 rtl/wb_stage_pipe.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_stage_pipe.sv
// Purpose: MEM/WB stage register plus write-back source mux, load extract, forwarding tap, retire counter.
// Latency: 1 cycle from mem_* capture to wb_*/fwd_* outputs (outputs are combinational from the stage register).
// Backpressure: wb_stall holds the whole stage; wb_flush (wins over stall) kills the captured instruction.
// Option: define WB_SUBWORD_LOAD_EN to enable big-endian byte/half load extraction on the MEM source.
module wb_stage_pipe #(
  parameter int DW    = 32,
  parameter int RAW   = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic [DW-1:0]    mem_read_data,
  input  logic [DW-1:0]    mem_alu_result,
  input  logic [DW-1:0]    mem_pc_plus4,
  input  logic [15:0]      mem_imm_hi,
  input  logic [RAW-1:0]   mem_reg_dest,
  input  logic             mem_reg_write,
  input  logic [1:0]       mem_wb_sel,
  input  logic [1:0]       mem_ld_size,
  input  logic             mem_ld_unsigned,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             wb_we,
  output logic [RAW-1:0]   wb_waddr,
  output logic [DW-1:0]    wb_wdata,
  output logic             fwd_valid,
  output logic [RAW-1:0]   fwd_addr,
  output logic [DW-1:0]    fwd_data,
  output logic [CNT_W-1:0] retire_cnt
);

  logic             r_valid;
  logic             r_reg_write;
  logic [RAW-1:0]   r_waddr;
  logic [1:0]       r_wb_sel;
  logic [DW-1:0]    r_alu;
  logic [DW-1:0]    r_rd;
  logic [DW-1:0]    r_pc4;
  logic [15:0]      r_imm;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [DW-1:0]    w_mem_data;
  logic [DW-1:0]    w_wdata;

  // Stage register: flush clears valid even while stalled; data fields only move when not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_waddr     <= '0;
      r_wb_sel    <= 2'd0;
      r_alu       <= '0;
      r_rd        <= '0;
      r_pc4       <= '0;
      r_imm       <= '0;
    end else begin
      if (wb_flush) begin
        r_valid <= 1'b0;
      end else if (!wb_stall) begin
        r_valid <= mem_valid;
      end
      if (!wb_stall) begin
        r_reg_write <= mem_reg_write;
        r_waddr     <= mem_reg_dest;
        r_wb_sel    <= mem_wb_sel;
        r_alu       <= mem_alu_result;
        r_rd        <= mem_read_data;
        r_pc4       <= mem_pc_plus4;
        r_imm       <= mem_imm_hi;
      end
    end
  end

  // Retire counter: one per live instruction actually accepted into the stage; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (mem_valid && !wb_stall && !wb_flush) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

`ifdef WB_SUBWORD_LOAD_EN
  logic [1:0]  r_ld_size;
  logic        r_ld_unsigned;
  logic [31:0] w_rd32;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [1:0]  w_ofs;

  // Load-shape fields travel with the instruction and obey the same stall/reset rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_size     <= 2'd0;
      r_ld_unsigned <= 1'b0;
    end else if (!wb_stall) begin
      r_ld_size     <= mem_ld_size;
      r_ld_unsigned <= mem_ld_unsigned;
    end
  end

  assign w_rd32 = 32'(r_rd);
  assign w_ofs  = r_alu[1:0];
  // Misaligned halves only look at ofs[1]; alignment traps belong to the MEM stage.
  assign w_half = w_ofs[1] ? w_rd32[15:0] : w_rd32[31:16];

  // Big-endian lane select and sign/zero extension of the loaded sub-word.
  always_comb begin
    w_byte = w_rd32[7:0];
    case (w_ofs)
      2'd0:    w_byte = w_rd32[31:24];
      2'd1:    w_byte = w_rd32[23:16];
      2'd2:    w_byte = w_rd32[15:8];
      default: w_byte = w_rd32[7:0];
    endcase
    case (r_ld_size)
      2'd0:    w_mem_data = {{(DW-8){w_byte[7] & ~r_ld_unsigned}}, w_byte};
      2'd1:    w_mem_data = {{(DW-16){w_half[15] & ~r_ld_unsigned}}, w_half};
      default: w_mem_data = r_rd;
    endcase
  end
`else
  // Without sub-word support the load shape is irrelevant: the word goes through untouched.
  logic w_unused_ld;
  assign w_unused_ld = ^{mem_ld_size, mem_ld_unsigned};
  assign w_mem_data  = r_rd;
`endif

  // Write-back source select from the registered fields.
  always_comb begin
    w_wdata = r_alu;
    case (r_wb_sel)
      2'd0:    w_wdata = r_alu;
      2'd1:    w_wdata = w_mem_data;
      2'd2:    w_wdata = r_pc4;
      default: w_wdata = DW'({r_imm, 16'b0});
    endcase
  end

  // Register $0 is hard-wired zero, so writes to it never leave the stage.
  assign wb_we      = r_valid & r_reg_write & (r_waddr != '0);
  assign wb_waddr   = r_waddr;
  assign wb_wdata   = w_wdata;
  assign fwd_valid  = wb_we;
  assign fwd_addr   = r_waddr;
  assign fwd_data   = w_wdata;
  assign retire_cnt = r_retire_cnt;

endmodule
